// File: rtl/step_sequencer.sv
// Eight-step pattern sequencer: walks stored oscillator masks, gates each for a
// programmable number of sixteenths of the step, and ORs the gated oscillators.
module step_sequencer #(
  parameter int SUB_DIV   = 125000,
  parameter int NUM_STEPS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       wr_en,
  input  logic [2:0] wr_step,
  input  logic [7:0] wr_mask,
  input  logic [3:0] gate_len,
  input  logic [7:0] osc_in,
  output logic [2:0] step,
  output logic       step_tick,
  output logic [7:0] gates,
  output logic       pwmout
);

  localparam int CW = $clog2(SUB_DIV);

  typedef enum logic {IDLE, PLAY} state_t;

  state_t        r_state;
  state_t        w_nextState;
  logic [CW-1:0] r_subCnt;
  logic [3:0]    r_subIdx;
  logic [2:0]    r_step;
  logic          r_stepTick;
  logic [7:0]    r_gates;
  logic [7:0]    r_pattern [8];

  logic w_advance;
  logic w_subWrap;
  logic w_stepWrap;
  logic w_gateEn;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (run)  w_nextState = PLAY;
      PLAY:    if (!run) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Counters only move while playing and still running; stopping clears them at once.
  assign w_advance  = (r_state == PLAY) && run;
  assign w_subWrap  = (r_subCnt == CW'(SUB_DIV - 1));
  assign w_stepWrap = w_subWrap && (r_subIdx == 4'd15);
  assign w_gateEn   = (r_state == PLAY) && (r_subIdx < gate_len);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_subCnt   <= '0;
      r_subIdx   <= '0;
      r_step     <= '0;
      r_stepTick <= 1'b0;
    end else if (!w_advance) begin
      r_subCnt   <= '0;
      r_subIdx   <= '0;
      r_step     <= '0;
      r_stepTick <= 1'b0;
    end else begin
      r_stepTick <= w_stepWrap;
      if (w_subWrap) begin
        r_subCnt <= '0;
        r_subIdx <= r_subIdx + 4'd1;
        if (r_subIdx == 4'd15)
          r_step <= (r_step == 3'(NUM_STEPS - 1)) ? 3'd0 : r_step + 3'd1;
      end else begin
        r_subCnt <= r_subCnt + CW'(1);
      end
    end
  end

  // Gate register samples the current step's stored mask, so it trails the counters by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_gates <= '0;
    else        r_gates <= r_pattern[r_step] & {8{w_gateEn}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) r_pattern[i] <= '0;
    end else if (wr_en) begin
      r_pattern[wr_step] <= wr_mask;
    end
  end

  assign step      = r_step;
  assign step_tick = r_stepTick;
  assign gates     = r_gates;
  assign pwmout    = |(osc_in & r_gates);

endmodule

// File: tb/tb_step_sequencer.sv
// Scoreboard bench for step_sequencer: a cycle-count reference model queues the
// expected outputs and an independent monitor compares them after each edge.
module tb_step_sequencer;

  localparam int SD       = 4;
  localparam int STEP_CYC = 16 * SD;
  localparam int LOOP_CYC = 8 * STEP_CYC;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_step = '0;
  logic [7:0] wr_mask = '0;
  logic [3:0] gate_len = '0;
  logic [7:0] osc_in = 8'hFF;
  logic [2:0] step;
  logic       step_tick;
  logic [7:0] gates;
  logic       pwmout;

  step_sequencer #(.SUB_DIV(SD), .NUM_STEPS(8)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .wr_en(wr_en), .wr_step(wr_step),
    .wr_mask(wr_mask), .gate_len(gate_len), .osc_in(osc_in), .step(step),
    .step_tick(step_tick), .gates(gates), .pwmout(pwmout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] step;
    logic       tick;
    logic [7:0] gates;
    logic [7:0] osc;
  } exp_t;

  exp_t       expQ[$];
  int         errors = 0;
  int         checks = 0;
  bit         mPlaying = 1'b0;
  int         mK = 0;
  logic [7:0] mPattern [8];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // One clock of stimulus; the model predicts the outputs after the coming rising edge.
  task automatic applyStimulus(input bit runV, input bit wrV, input logic [2:0] wsV,
                               input logic [7:0] wmV, input logic [3:0] glV, input logic [7:0] oscV);
    exp_t e;
    int   curStep;
    int   curSub;
    @(negedge clk);
    run = runV; wr_en = wrV; wr_step = wsV; wr_mask = wmV; gate_len = glV; osc_in = oscV;
    e.osc = oscV;
    if (!rst_n) begin
      mPlaying = 1'b0;
      mK = 0;
      for (int i = 0; i < 8; i++) mPattern[i] = 8'h00;
      e.step = 3'd0; e.tick = 1'b0; e.gates = 8'h00;
    end else begin
      curStep = mPlaying ? (mK / STEP_CYC) % 8 : 0;
      curSub  = mPlaying ? (mK / SD) % 16 : 0;
      e.gates = (mPlaying && curSub < int'(glV)) ? mPattern[curStep] : 8'h00;
      if (wrV) mPattern[wsV] = wmV;
      e.tick = 1'b0;
      if (!mPlaying) begin
        mPlaying = runV;
        mK = 0;
      end else if (runV) begin
        mK++;
        e.tick = (mK % STEP_CYC) == 0;
      end else begin
        mPlaying = 1'b0;
        mK = 0;
      end
      e.step = mPlaying ? 3'((mK / STEP_CYC) % 8) : 3'd0;
    end
    expQ.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("step", 32'(step), 32'(e.step));
        checkOutput("step_tick", 32'(step_tick), 32'(e.tick));
        checkOutput("gates", 32'(gates), 32'(e.gates));
        checkOutput("pwmout", 32'(pwmout), 32'(|(e.osc & e.gates)));
      end
    end
  end

  initial begin : stimulus
    bit         r;
    bit         wr;
    logic [2:0] ws;
    logic [7:0] wm;
    logic [3:0] gl;

    for (int i = 0; i < 8; i++) mPattern[i] = 8'h00;
    #12;
    checkOutput("reset_step", 32'(step), 32'd0);
    checkOutput("reset_gates", 32'(gates), 32'd0);
    checkOutput("reset_tick", 32'(step_tick), 32'd0);
    checkOutput("reset_pwm", 32'(pwmout), 32'd0);
    repeat (3) applyStimulus(1'b0, 1'b0, 3'd0, 8'h00, 4'd8, 8'hFF);
    rst_n = 1'b1;

    $display("[TB] basic two-slot pattern, gate_len 8");
    applyStimulus(1'b0, 1'b1, 3'd0, 8'h01, 4'd8, 8'hFF);
    applyStimulus(1'b0, 1'b1, 3'd1, 8'h80, 4'd8, 8'hFF);
    for (int i = 0; i < 70; i++) applyStimulus(1'b1, 1'b0, 3'd0, 8'h00, 4'd8, 8'($urandom));

    $display("[TB] eight full steps, all slots 0xFF, gate_len 15");
    applyStimulus(1'b0, 1'b0, 3'd0, 8'h00, 4'd15, 8'hFF);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 3'(i), 8'hFF, 4'd15, 8'hFF);
    for (int i = 0; i < LOOP_CYC + 8; i++) begin
      if (mPlaying && ((mK + 1) % LOOP_CYC == 0))
        applyStimulus(1'b1, 1'b1, 3'd0, 8'h5A, 4'd15, 8'($urandom));
      else
        applyStimulus(1'b1, 1'b0, 3'd0, 8'h00, 4'd15, 8'($urandom));
    end

    $display("[TB] gate_len 0 mutes everything");
    for (int i = 0; i < 70; i++) applyStimulus(1'b1, 1'b0, 3'd0, 8'h00, 4'd0, 8'hFF);

    $display("[TB] stop mid-step 3, then restart and rewrite playing slot");
    applyStimulus(1'b0, 1'b1, 3'd0, 8'hFF, 4'd8, 8'hFF);
    for (int i = 0; i < 3 * STEP_CYC + 30; i++) applyStimulus(1'b1, 1'b0, 3'd0, 8'h00, 4'd8, 8'hFF);
    repeat (4) applyStimulus(1'b0, 1'b0, 3'd0, 8'h00, 4'd8, 8'hFF);
    for (int i = 0; i < 80; i++) begin
      if (i == 10) applyStimulus(1'b1, 1'b1, 3'd0, 8'h3C, 4'd8, 8'hFF);
      else         applyStimulus(1'b1, 1'b0, 3'd0, 8'h00, 4'd8, 8'hFF);
    end

    $display("[TB] asynchronous reset while gates are open");
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_step", 32'(step), 32'd0);
    checkOutput("async_gates", 32'(gates), 32'd0);
    checkOutput("async_tick", 32'(step_tick), 32'd0);
    checkOutput("async_pwm", 32'(pwmout), 32'd0);
    repeat (2) applyStimulus(1'b1, 1'b0, 3'd0, 8'h00, 4'd15, 8'hFF);
    applyStimulus(1'b0, 1'b0, 3'd0, 8'h00, 4'd15, 8'hFF);
    rst_n = 1'b1;
    for (int i = 0; i < 70; i++) applyStimulus(1'b1, 1'b0, 3'd0, 8'h00, 4'd15, 8'hFF);

    $display("[TB] randomized play");
    r  = 1'b1;
    gl = 4'd8;
    for (int i = 0; i < 3000; i++) begin
      if (r && $urandom_range(0, 199) == 0) r = 1'b0;
      else if (!r && $urandom_range(0, 7) == 0) r = 1'b1;
      if ($urandom_range(0, 15) == 0) gl = 4'($urandom);
      wr = ($urandom_range(0, 7) == 0);
      ws = 3'($urandom);
      wm = 8'($urandom);
      if (mPlaying && r && ((mK + 1) % LOOP_CYC == 0)) begin
        wr = 1'b1;
        ws = 3'd0;
      end
      applyStimulus(r, wr, ws, wm, gl, 8'($urandom));
    end

    repeat (4) @(posedge clk);
    #2;
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
